// File: rtl/dds_pkg.sv
// Shared mode encoding and quarter-wave table generator for the sweep DDS.
package dds_pkg;

  typedef enum logic [1:0] {
    TONE = 2'd0,
    SAW  = 2'd1,
    TRI  = 2'd2,
    RSVD = 2'd3
  } dds_mode_e;

  localparam real PI = 3.14159265358979323846;

  // Half-sample offset keeps the quadrant mirror exact without a guard entry.
  function automatic int rom_entry(input int idx, input int dw, input int aw);
    real x;
    x = $sin(2.0 * PI * (real'(idx) + 0.5) / real'(2 ** aw)) * real'((2 ** (dw - 1)) - 1);
    return $rtoi(x + 0.5);
  endfunction

endpackage

// File: rtl/sweep_dds_if.sv
// Configuration and sample bus of the sweep DDS.
// No backpressure: the sink accepts one sample per valid cycle.
interface sweep_dds_if #(
  parameter int PW = 32,
  parameter int DW = 10
);

  logic                 en;
  logic                 cfg_load;
  logic [1:0]           mode;
  logic [PW-1:0]        f_start;
  logic [PW-1:0]        f_stop;
  logic [PW-1:0]        f_step;
  logic [PW-1:0]        phase_off;
  logic                 ph_clr;
  logic signed [DW-1:0] sin_out;
  logic signed [DW-1:0] cos_out;
  logic                 out_valid;
  logic                 sweep_wrap;

  modport master (
    output en, cfg_load, mode, f_start, f_stop, f_step, phase_off, ph_clr,
    input  sin_out, cos_out, out_valid, sweep_wrap
  );

  modport slave (
    input  en, cfg_load, mode, f_start, f_stop, f_step, phase_off, ph_clr,
    output sin_out, cos_out, out_valid, sweep_wrap
  );

endinterface

// File: rtl/qw_sine_rom.sv
// Quarter-wave sine table with a registered read port.
// Latency 1 clock; no backpressure, a read is issued every cycle.
module qw_sine_rom
  import dds_pkg::*;
#(
  parameter int DW = 10,
  parameter int AW = 13
) (
  input  logic                 clk,
  input  logic [AW-3:0]        addr,
  output logic signed [DW-1:0] data
);

  localparam int DEPTH = 2 ** (AW - 2);

  logic signed [DW-1:0] rom_tab [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign rom_tab[i] = DW'(rom_entry(i, DW, AW));
  end

  always_ff @(posedge clk) begin
    data <= rom_tab[addr];
  end

endmodule

// File: rtl/sweep_dds.sv
// Quadrature NCO / chirp source: tone, sawtooth or triangle frequency sweep.
// Latency 4 clocks accumulator-to-output; no backpressure, one sample per en cycle.
module sweep_dds
  import dds_pkg::*;
#(
  parameter int PW = 32,
  parameter int DW = 10,
  parameter int AW = 13
) (
  input logic        clk,
  input logic        rst_n,
  sweep_dds_if.slave bus
);

  localparam logic [PW-1:0] QUARTER = {2'b01, {(PW-2){1'b0}}};

  dds_mode_e     mode_r;
  logic [PW-1:0] start_r, stop_r, step_r, off_r;
  logic [PW-1:0] acc, freq_cur, freq_nxt;
  logic          dir_down, dir_nxt, wrap_nxt, wrap_q;
  logic [PW:0]   up_sum, down_floor;
  logic          degenerate;

  // One extra bit so the sweep compares never overflow.
  assign up_sum     = {1'b0, freq_cur} + {1'b0, step_r};
  assign down_floor = {1'b0, start_r} + {1'b0, step_r};
  assign degenerate = (step_r == '0) || (start_r >= stop_r);

  always_comb begin
    freq_nxt = freq_cur;
    dir_nxt  = dir_down;
    wrap_nxt = 1'b0;
    if (mode_r == SAW || mode_r == TRI) begin
      if (degenerate) begin
        freq_nxt = start_r;
      end else if (mode_r == SAW) begin
        if (up_sum > {1'b0, stop_r}) begin
          freq_nxt = start_r;
          wrap_nxt = 1'b1;
        end else begin
          freq_nxt = up_sum[PW-1:0];
        end
      end else if (!dir_down) begin
        if (up_sum >= {1'b0, stop_r}) begin
          freq_nxt = stop_r;
          dir_nxt  = 1'b1;
        end else begin
          freq_nxt = up_sum[PW-1:0];
        end
      end else begin
        if ({1'b0, freq_cur} <= down_floor) begin
          freq_nxt = start_r;
          dir_nxt  = 1'b0;
          wrap_nxt = 1'b1;
        end else begin
          freq_nxt = freq_cur - step_r;
        end
      end
    end
  end

  // Retune leaves the accumulator alone so the phase stays continuous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r   <= TONE;
      start_r  <= '0;
      stop_r   <= '0;
      step_r   <= '0;
      off_r    <= '0;
      acc      <= '0;
      freq_cur <= '0;
      dir_down <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (bus.cfg_load) begin
        mode_r   <= dds_mode_e'(bus.mode);
        start_r  <= bus.f_start;
        stop_r   <= bus.f_stop;
        step_r   <= bus.f_step;
        off_r    <= bus.phase_off;
        freq_cur <= bus.f_start;
        dir_down <= 1'b0;
      end else if (bus.en) begin
        freq_cur <= freq_nxt;
        dir_down <= dir_nxt;
        wrap_q   <= wrap_nxt;
      end
      if (bus.ph_clr) begin
        acc <= '0;
      end else if (bus.en) begin
        acc <= acc + freq_cur;
      end
    end
  end

  logic [PW-1:0]        psum_s1, pcos_s1;
  logic                 vld_s1;
  logic [AW-1:0]        idx_sin, idx_cos;
  logic [AW-3:0]        addr_sin_s2, addr_cos_s2;
  logic                 neg_sin_s2, neg_cos_s2, vld_s2;
  logic signed [DW-1:0] rom_sin_s3, rom_cos_s3;
  logic                 neg_sin_s3, neg_cos_s3, vld_s3;
  logic signed [DW-1:0] sin_q, cos_q;
  logic                 vld_q;
  logic                 unused_low;

  assign idx_sin    = psum_s1[PW-1 -: AW];
  assign idx_cos    = pcos_s1[PW-1 -: AW];
  assign unused_low = ^{psum_s1[PW-AW-1:0], pcos_s1[PW-AW-1:0]};

  // Odd quadrants read the table backwards; the upper half is negated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psum_s1     <= '0;
      pcos_s1     <= '0;
      vld_s1      <= 1'b0;
      addr_sin_s2 <= '0;
      addr_cos_s2 <= '0;
      neg_sin_s2  <= 1'b0;
      neg_cos_s2  <= 1'b0;
      vld_s2      <= 1'b0;
      neg_sin_s3  <= 1'b0;
      neg_cos_s3  <= 1'b0;
      vld_s3      <= 1'b0;
      sin_q       <= '0;
      cos_q       <= '0;
      vld_q       <= 1'b0;
    end else begin
      psum_s1     <= acc + off_r;
      pcos_s1     <= acc + off_r + QUARTER;
      vld_s1      <= bus.en;
      addr_sin_s2 <= idx_sin[AW-2] ? ~idx_sin[AW-3:0] : idx_sin[AW-3:0];
      addr_cos_s2 <= idx_cos[AW-2] ? ~idx_cos[AW-3:0] : idx_cos[AW-3:0];
      neg_sin_s2  <= idx_sin[AW-1];
      neg_cos_s2  <= idx_cos[AW-1];
      vld_s2      <= vld_s1;
      neg_sin_s3  <= neg_sin_s2;
      neg_cos_s3  <= neg_cos_s2;
      vld_s3      <= vld_s2;
      vld_q       <= vld_s3;
      if (vld_s3) begin
        sin_q <= neg_sin_s3 ? -rom_sin_s3 : rom_sin_s3;
        cos_q <= neg_cos_s3 ? -rom_cos_s3 : rom_cos_s3;
      end
    end
  end

  qw_sine_rom #(.DW(DW), .AW(AW)) u_rom_sin (
    .clk  (clk),
    .addr (addr_sin_s2),
    .data (rom_sin_s3)
  );

  qw_sine_rom #(.DW(DW), .AW(AW)) u_rom_cos (
    .clk  (clk),
    .addr (addr_cos_s2),
    .data (rom_cos_s3)
  );

  assign bus.sin_out    = sin_q;
  assign bus.cos_out    = cos_q;
  assign bus.out_valid  = vld_q;
  assign bus.sweep_wrap = wrap_q;

endmodule

// File: tb/tb_sweep_dds.sv
// Randomized and directed bench for sweep_dds against a full-wave sine reference.
module tb_sweep_dds;

  localparam int PW = 32;
  localparam int DW = 10;
  localparam int AW = 13;
  localparam longint MOD = 64'h1_0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sweep_dds_if #(.PW(PW), .DW(DW)) ifc ();

  sweep_dds #(.PW(PW), .DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  typedef struct {
    bit     v;
    longint ph;
  } tap_t;

  longint m_acc, m_freq, m_start, m_stop, m_step, m_off;
  int     m_mode;
  bit     m_down, m_valid, m_wrap;
  longint m_sin, m_cos;
  tap_t   pipe[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Direct full-wave sine of the top AW phase bits, symmetric rounding.
  function automatic longint ref_sample(input longint ph);
    longint k;
    real    r;
    k = (ph & (MOD - 1)) >> (PW - AW);
    r = $sin(2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / real'(2 ** AW))
        * real'((2 ** (DW - 1)) - 1);
    if (r >= 0.0) return longint'($rtoi(r + 0.5));
    return -longint'($rtoi(-r + 0.5));
  endfunction

  task automatic model_reset();
    m_acc = 0; m_freq = 0; m_start = 0; m_stop = 0; m_step = 0; m_off = 0;
    m_mode = 0; m_down = 0; m_valid = 0; m_wrap = 0; m_sin = 0; m_cos = 0;
    pipe.delete();
  endtask

  task automatic model_edge();
    longint acc0, freq0, nf;
    bit     nd, w;
    tap_t   t;
    acc0 = m_acc;
    freq0 = m_freq;
    pipe.push_back('{ifc.en, (acc0 + m_off) % MOD});
    if (pipe.size() == 4) begin
      t = pipe.pop_front();
      m_valid = t.v;
      if (t.v) begin
        m_sin = ref_sample(t.ph);
        m_cos = ref_sample((t.ph + MOD / 4) % MOD);
      end
    end
    w = 0;
    nf = m_freq;
    nd = m_down;
    if (ifc.cfg_load) begin
      m_mode = int'(ifc.mode); m_start = ifc.f_start; m_stop = ifc.f_stop;
      m_step = ifc.f_step; m_off = ifc.phase_off;
      nf = ifc.f_start; nd = 0;
    end else if (ifc.en && (m_mode == 1 || m_mode == 2)) begin
      if (m_step == 0 || m_start >= m_stop) nf = m_start;
      else if (m_mode == 1) begin
        if (m_freq + m_step > m_stop) begin nf = m_start; w = 1; end
        else nf = m_freq + m_step;
      end else if (!m_down) begin
        if (m_freq + m_step >= m_stop) begin nf = m_stop; nd = 1; end
        else nf = m_freq + m_step;
      end else if (m_freq <= m_start + m_step) begin
        nf = m_start; nd = 0; w = 1;
      end else nf = m_freq - m_step;
    end
    if (ifc.ph_clr) m_acc = 0;
    else if (ifc.en) m_acc = (acc0 + freq0) % MOD;
    m_freq = nf;
    m_down = nd;
    m_wrap = w;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    @(negedge clk);
    check("out_valid", ifc.out_valid, m_valid);
    check("sin_out", ifc.sin_out, m_sin);
    check("cos_out", ifc.cos_out, m_cos);
    check("sweep_wrap", ifc.sweep_wrap, m_wrap);
    check("freq_cur", dut.freq_cur, m_freq);
  endtask

  task automatic load(input int md, input longint st, input longint sp, input longint stp,
                      input longint off, input bit clr);
    ifc.mode = 2'(md); ifc.f_start = 32'(st); ifc.f_stop = 32'(sp);
    ifc.f_step = 32'(stp); ifc.phase_off = 32'(off);
    ifc.cfg_load = 1'b1; ifc.ph_clr = clr;
    tick();
    ifc.cfg_load = 1'b0; ifc.ph_clr = 1'b0;
  endtask

  initial begin
    int first, nval, wraps;
    longint mx, mn;
    logic [31:0] a, b;

    model_reset();
    rst_n = 1'b0;
    ifc.en = 0; ifc.cfg_load = 0; ifc.mode = 0; ifc.f_start = 0; ifc.f_stop = 0;
    ifc.f_step = 0; ifc.phase_off = 0; ifc.ph_clr = 0;
    tick();
    tick();
    rst_n = 1'b1;

    // Tone at 1/16 of the sample rate: latency, peak and trough.
    load(0, 64'h1000_0000, 0, 0, 0, 0);
    ifc.en = 1'b1;
    first = -1; nval = 0; mx = -1000; mn = 1000;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (ifc.out_valid && first < 0) first = i;
      if (ifc.out_valid && nval < 16) begin
        nval++;
        if (ifc.sin_out > mx) mx = ifc.sin_out;
        if (ifc.sin_out < mn) mn = ifc.sin_out;
      end
    end
    check("t1_latency", first, 3);
    check("t1_peak", mx, 511);
    check("t1_trough", mn, -511);

    // Quadrature at fixed phase offsets.
    load(0, 0, 0, 0, 64'h4000_0000, 1);
    repeat (5) tick();
    check("t2_sin_90", ifc.sin_out, 511);
    check("t2_cos_90", ifc.cos_out, 0);
    load(0, 0, 0, 0, 64'h8000_0000, 1);
    repeat (5) tick();
    check("t2_sin_180", ifc.sin_out, 0);
    check("t2_cos_180", ifc.cos_out, -511);

    // Sawtooth and triangle sweeps.
    load(1, 100, 400, 100, 0, 1);
    wraps = 0;
    for (int i = 0; i < 12; i++) begin tick(); wraps += int'(ifc.sweep_wrap); end
    check("saw_wraps", wraps, 3);
    load(2, 100, 400, 100, 0, 1);
    wraps = 0;
    for (int i = 0; i < 12; i++) begin tick(); wraps += int'(ifc.sweep_wrap); end
    check("tri_wraps", wraps, 2);

    // Alternating enable, then coherent restart.
    load(0, 64'h0123_4567, 0, 0, 64'h0000_1000, 0);
    for (int i = 0; i < 16; i++) begin ifc.en = (i % 2 == 0); tick(); end
    ifc.en = 1'b1;
    load(0, 64'h0400_0000, 0, 0, 0, 1);
    repeat (4) tick();
    check("restart_valid", ifc.out_valid, 1);
    check("restart_sin", ifc.sin_out, 0);
    check("restart_cos", ifc.cos_out, 511);

    // Random traffic including retunes, clears and degenerate sweeps.
    for (int i = 0; i < 1500; i++) begin
      ifc.en = ($urandom_range(0, 3) != 0);
      ifc.ph_clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 39) == 0) begin
        a = $urandom; b = $urandom;
        if ($urandom_range(0, 3) != 0 && a > b) begin ifc.f_start = b; ifc.f_stop = a; end
        else begin ifc.f_start = a; ifc.f_stop = b; end
        ifc.f_step = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 6));
        ifc.mode = 2'($urandom_range(0, 3));
        ifc.phase_off = $urandom;
        ifc.cfg_load = 1'b1;
      end
      tick();
      ifc.cfg_load = 1'b0;
      ifc.ph_clr = 1'b0;
    end

    // Asynchronous reset in the middle of a sweep.
    ifc.en = 1'b1;
    load(1, 1000, 64'h0010_0000, 4096, 12345, 0);
    repeat (50) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_sin", ifc.sin_out, 0);
    check("arst_cos", ifc.cos_out, 0);
    check("arst_valid", ifc.out_valid, 0);
    check("arst_wrap", ifc.sweep_wrap, 0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    repeat (8) tick();
    check("post_rst_sin", ifc.sin_out, 0);
    check("post_rst_cos", ifc.cos_out, 511);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
